// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch (I) and load/store (D).
// Define MEM_ARB_RR_EN for round-robin between simultaneous requesters; default is fixed D-over-I priority.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  m_req,
    output logic                  m_we,
    output logic [DATA_W/8-1:0]   m_be,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    input  logic                  m_gnt,
    input  logic                  m_rvalid,
    input  logic [DATA_W-1:0]     m_rdata,
    output logic [CNT_W-1:0]      i_stall_cnt,
    output logic [CNT_W-1:0]      d_stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {ST_IDLE, ST_BUSY} state_e;
    typedef enum logic {PORT_I, PORT_D} port_e;

    state_e           state_q, state_d;
    port_e            owner_q, owner_d;
    port_e            sel;
    logic             slot_open;
    logic             rsp;
    logic             grant;
    logic [CNT_W-1:0] i_stall_q, i_stall_d;
    logic [CNT_W-1:0] d_stall_q, d_stall_d;

`ifdef MEM_ARB_RR_EN
    port_e last_q, last_d;
`endif

    // Read data is broadcast; the rvalid strobes decide who consumes it.
    assign i_rdata     = m_rdata;
    assign d_rdata     = m_rdata;
    assign i_stall_cnt = i_stall_q;
    assign d_stall_cnt = d_stall_q;

    always_comb begin
        slot_open = (state_q == ST_IDLE) || m_rvalid;

        sel = d_req ? PORT_D : PORT_I;
`ifdef MEM_ARB_RR_EN
        if (i_req && d_req) begin
            sel = (last_q == PORT_D) ? PORT_I : PORT_D;
        end
`endif

        // Outputs are gated by rst so nothing leaks out while reset is held.
        m_req = !rst && slot_open && (i_req || d_req);
        if (sel == PORT_D) begin
            m_we    = d_we;
            m_be    = d_be;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end else begin
            m_we    = 1'b0;
            m_be    = '1;
            m_addr  = i_addr;
            m_wdata = '0;
        end

        i_gnt = m_req && m_gnt && (sel == PORT_I);
        d_gnt = m_req && m_gnt && (sel == PORT_D);
        grant = i_gnt || d_gnt;

        // A response with nothing outstanding is dropped.
        rsp      = !rst && (state_q == ST_BUSY) && m_rvalid;
        i_rvalid = rsp && (owner_q == PORT_I);
        d_rvalid = rsp && (owner_q == PORT_D);
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
`ifdef MEM_ARB_RR_EN
        last_d  = last_q;
`endif
        if (grant) begin
            state_d = ST_BUSY;
            owner_d = sel;
`ifdef MEM_ARB_RR_EN
            last_d  = sel;
`endif
        end else if (rsp) begin
            state_d = ST_IDLE;
        end

        i_stall_d = i_stall_q;
        d_stall_d = d_stall_q;
        if (i_req && !i_gnt && (i_stall_q != CNT_MAX)) i_stall_d = i_stall_q + CNT_ONE;
        if (d_req && !d_gnt && (d_stall_q != CNT_MAX)) d_stall_d = d_stall_q + CNT_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= PORT_I;
            i_stall_q <= '0;
            d_stall_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            i_stall_q <= i_stall_d;
            d_stall_q <= d_stall_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= PORT_I;
        else     last_q <= last_d;
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, i_gnt, i_rvalid;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [BW-1:0] d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          m_req, m_we, m_gnt, m_rvalid;
    logic [BW-1:0] m_be;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [CW-1:0] i_stall_cnt, d_stall_cnt;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .i_stall_cnt(i_stall_cnt), .d_stall_cnt(d_stall_cnt)
    );

    task automatic idle_inputs();
        i_req = 0; i_addr = '0;
        d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
        m_gnt = 0; m_rvalid = 0; m_rdata = '0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cyc();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        @(posedge clk); @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        i_req = 1; d_req = 1; m_gnt = 1; m_rvalid = 1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (m_req !== 1'b0) $display("FAIL reset_m_req: got %b expected 0", m_req); else passes++;
        checks++; if (i_gnt !== 1'b0) $display("FAIL reset_i_gnt: got %b expected 0", i_gnt); else passes++;
        checks++; if (d_gnt !== 1'b0) $display("FAIL reset_d_gnt: got %b expected 0", d_gnt); else passes++;
        checks++; if ({i_rvalid, d_rvalid} !== 2'b00) $display("FAIL reset_rvalid: got %b expected 00", {i_rvalid, d_rvalid}); else passes++;
        checks++; if (i_stall_cnt !== 4'd0) $display("FAIL reset_i_cnt: got %0d expected 0", i_stall_cnt); else passes++;
        checks++; if (d_stall_cnt !== 4'd0) $display("FAIL reset_d_cnt: got %0d expected 0", d_stall_cnt); else passes++;
        do_reset();
    endtask

    task automatic test_single_fetch();
        do_reset();
        i_req = 1; i_addr = 32'h44; m_gnt = 1;
        @(negedge clk);
        checks++; if (i_gnt !== 1'b1) $display("FAIL fetch_gnt: got %b expected 1", i_gnt); else passes++;
        checks++; if ({m_req, m_we, m_be, m_addr, m_wdata} !== {1'b1, 1'b0, 4'hf, 32'h44, 32'h0})
            $display("FAIL fetch_mreq: got req=%b we=%b be=%h addr=%h wd=%h expected 1 0 f 00000044 00000000", m_req, m_we, m_be, m_addr, m_wdata);
        else passes++;
        next_cyc();
        i_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h13;
        @(negedge clk);
        checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h13) $display("FAIL fetch_rsp: got rv=%b data=%h expected 1 00000013", i_rvalid, i_rdata); else passes++;
        checks++; if (d_rvalid !== 1'b0) $display("FAIL fetch_d_rvalid: got %b expected 0", d_rvalid); else passes++;
        next_cyc();
        idle_inputs();
    endtask

    task automatic test_conflict();
        do_reset();
        i_req = 1; i_addr = 32'h48; d_req = 1; d_we = 0; d_addr = 32'h2000; m_gnt = 1;
        @(negedge clk);
        checks++; if ({d_gnt, i_gnt} !== 2'b10) $display("FAIL conflict_first: got d_gnt,i_gnt=%b expected 10", {d_gnt, i_gnt}); else passes++;
        checks++; if (m_addr !== 32'h2000) $display("FAIL conflict_addr: got %h expected 00002000", m_addr); else passes++;
        next_cyc();
        d_req = 0; m_rvalid = 1; m_rdata = 32'hcafe0001;
        @(negedge clk);
        checks++; if (d_rvalid !== 1'b1) $display("FAIL conflict_d_rvalid: got %b expected 1", d_rvalid); else passes++;
        checks++; if (i_gnt !== 1'b1 || m_addr !== 32'h48) $display("FAIL conflict_b2b: got i_gnt=%b addr=%h expected 1 00000048", i_gnt, m_addr); else passes++;
        checks++; if (i_stall_cnt !== 4'd1) $display("FAIL conflict_stall: got %0d expected 1", i_stall_cnt); else passes++;
        next_cyc();
        i_req = 0; m_gnt = 0; m_rdata = 32'h13;
        @(negedge clk);
        checks++; if ({i_rvalid, d_rvalid} !== 2'b10) $display("FAIL conflict_i_rsp: got %b expected 10", {i_rvalid, d_rvalid}); else passes++;
        checks++; if (i_stall_cnt !== 4'd1) $display("FAIL conflict_stall_hold: got %0d expected 1", i_stall_cnt); else passes++;
        next_cyc();
        idle_inputs();
    endtask

    task automatic test_store_ack();
        do_reset();
        d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h2004; d_wdata = 32'hdeadbeef; m_gnt = 1;
        @(negedge clk);
        checks++; if ({d_gnt, m_we, m_be, m_addr, m_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h2004, 32'hdeadbeef})
            $display("FAIL store_req: got gnt=%b we=%b be=%b addr=%h wd=%h expected 1 1 0011 00002004 deadbeef", d_gnt, m_we, m_be, m_addr, m_wdata);
        else passes++;
        next_cyc();
        d_req = 0; m_gnt = 0; m_rvalid = 1;
        @(negedge clk);
        checks++; if ({d_rvalid, i_rvalid} !== 2'b10) $display("FAIL store_ack: got d,i rvalid=%b expected 10", {d_rvalid, i_rvalid}); else passes++;
        next_cyc();
        idle_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        i_req = 1; i_addr = 32'h100; m_gnt = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (i_gnt !== 1'b0 || m_req !== 1'b1) $display("FAIL bp_wait%0d: got i_gnt=%b m_req=%b expected 0 1", c, i_gnt, m_req); else passes++;
            next_cyc();
        end
        m_gnt = 1;
        @(negedge clk);
        checks++; if (i_gnt !== 1'b1) $display("FAIL bp_gnt: got %b expected 1", i_gnt); else passes++;
        checks++; if (i_stall_cnt !== 4'd3) $display("FAIL bp_stall: got %0d expected 3", i_stall_cnt); else passes++;
        next_cyc();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        d_req = 1; d_addr = 32'h3000; i_req = 1; i_addr = 32'h200; m_gnt = 1;
        @(negedge clk);
        checks++; if (d_gnt !== 1'b1) $display("FAIL rmid_gnt: got %b expected 1", d_gnt); else passes++;
        next_cyc();
        idle_inputs();
        rst = 1;
        @(negedge clk);
        checks++; if ({m_req, d_rvalid} !== 2'b00) $display("FAIL rmid_in_reset: got m_req,d_rvalid=%b expected 00", {m_req, d_rvalid}); else passes++;
        next_cyc();
        rst = 0; m_rvalid = 1;
        @(negedge clk);
        checks++; if ({d_rvalid, i_rvalid} !== 2'b00) $display("FAIL rmid_late_rsp: got %b expected 00", {d_rvalid, i_rvalid}); else passes++;
        checks++; if ({i_stall_cnt, d_stall_cnt} !== 8'h00) $display("FAIL rmid_cnt: got i=%0d d=%0d expected 0 0", i_stall_cnt, d_stall_cnt); else passes++;
        next_cyc();
        m_rvalid = 0; i_req = 1; i_addr = 32'h204; m_gnt = 1;
        @(negedge clk);
        checks++; if (i_gnt !== 1'b1) $display("FAIL rmid_idle: got i_gnt=%b expected 1", i_gnt); else passes++;
        next_cyc();
        idle_inputs();
    endtask

    task automatic test_priority();
        bit [3:0] exp_d;
`ifdef MEM_ARB_RR_EN
        exp_d = 4'b0101;
`else
        exp_d = 4'b1111;
`endif
        do_reset();
        i_req = 1; d_req = 1; d_addr = 32'h4000; i_addr = 32'h80; m_gnt = 1;
        for (int c = 0; c < 4; c++) begin
            m_rvalid = (c != 0);
            @(negedge clk);
            checks++; if ({d_gnt, i_gnt} !== {exp_d[c], ~exp_d[c]})
                $display("FAIL prio_grant%0d: got d,i=%b expected %b", c, {d_gnt, i_gnt}, {exp_d[c], ~exp_d[c]});
            else passes++;
            next_cyc();
        end
        idle_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        i_req = 1; d_req = 1; m_gnt = 0;
        repeat (20) next_cyc();
        @(negedge clk);
        checks++; if (i_stall_cnt !== 4'd15) $display("FAIL sat_i: got %0d expected 15", i_stall_cnt); else passes++;
        checks++; if (d_stall_cnt !== 4'd15) $display("FAIL sat_d: got %0d expected 15", d_stall_cnt); else passes++;
        next_cyc();
        idle_inputs();
    endtask

    // Transaction-level reference: one outstanding request with a random memory latency.
    task automatic test_random();
        bit busy = 0, owner_d = 0, last_d = 0, rv, open, sel_d, ex_mreq, ex_ig, ex_dg;
        int cd = 0, icnt = 0, dcnt = 0, errs = 0;
        logic [AW-1:0] ex_addr;
        logic [DW-1:0] ex_wd;
        logic [BW-1:0] ex_be;
        logic          ex_we;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (!i_req && ($urandom % 3 == 0)) begin
                i_req = 1; i_addr = $urandom;
            end
            if (!d_req && ($urandom % 3 == 0)) begin
                d_req = 1; d_we = $urandom; d_be = $urandom; d_addr = $urandom; d_wdata = $urandom;
            end
            if (busy) begin
                cd--; rv = (cd == 0);
            end else begin
                rv = ($urandom % 8 == 0);
            end
            m_rvalid = rv; m_rdata = $urandom; m_gnt = ($urandom % 4 != 0);

            open = !busy || rv;
            if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
                sel_d = !last_d;
`else
                sel_d = 1;
`endif
            end else begin
                sel_d = d_req;
            end
            ex_mreq = open && (i_req || d_req);
            ex_ig   = ex_mreq && m_gnt && !sel_d;
            ex_dg   = ex_mreq && m_gnt && sel_d;
            ex_addr = sel_d ? d_addr : i_addr;
            ex_we   = sel_d ? d_we : 1'b0;
            ex_be   = sel_d ? d_be : 4'hf;
            ex_wd   = sel_d ? d_wdata : 32'h0;

            @(negedge clk);
            checks++; if ({m_req, i_gnt, d_gnt} !== {ex_mreq, ex_ig, ex_dg}) begin
                $display("FAIL rnd_gnt c%0d: got req,ig,dg=%b expected %b", c, {m_req, i_gnt, d_gnt}, {ex_mreq, ex_ig, ex_dg}); errs++;
            end else passes++;
            checks++; if ({i_rvalid, d_rvalid} !== {busy && rv && !owner_d, busy && rv && owner_d}) begin
                $display("FAIL rnd_rvalid c%0d: got i,d=%b expected %b", c, {i_rvalid, d_rvalid}, {busy && rv && !owner_d, busy && rv && owner_d}); errs++;
            end else passes++;
            checks++; if (i_rdata !== m_rdata || d_rdata !== m_rdata) begin
                $display("FAIL rnd_rdata c%0d: got i=%h d=%h expected %h", c, i_rdata, d_rdata, m_rdata); errs++;
            end else passes++;
            if (ex_mreq) begin
                checks++; if ({m_addr, m_we, m_be, m_wdata} !== {ex_addr, ex_we, ex_be, ex_wd}) begin
                    $display("FAIL rnd_mux c%0d: got %h %b %h %h expected %h %b %h %h", c, m_addr, m_we, m_be, m_wdata, ex_addr, ex_we, ex_be, ex_wd); errs++;
                end else passes++;
            end
            checks++; if (i_stall_cnt !== CW'(icnt) || d_stall_cnt !== CW'(dcnt)) begin
                $display("FAIL rnd_cnt c%0d: got i=%0d d=%0d expected %0d %0d", c, i_stall_cnt, d_stall_cnt, icnt, dcnt); errs++;
            end else passes++;
            if (errs > 20) break;

            if (i_req && !ex_ig && icnt < 15) icnt++;
            if (d_req && !ex_dg && dcnt < 15) dcnt++;
            if (ex_ig || ex_dg) begin
                busy = 1; owner_d = sel_d; last_d = sel_d; cd = $urandom_range(1, 3);
            end else if (busy && rv) begin
                busy = 0;
            end
            next_cyc();
            if (ex_ig) i_req = 0;
            if (ex_dg) d_req = 0;
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_conflict();
        test_store_ack();
        test_backpressure();
        test_reset_mid();
        test_priority();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the core's single-port unified memory between the IF-stage instruction fetch port and the MEM-stage load/store port.
- Sits between the pipeline and the memory array.
- Allows one outstanding transaction and routes each response back to the port that owns it.
- Counts stall cycles per port so the test benches can check pipeline efficiency alongside the pass/fail result.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- CNT_W, 16, width of the saturating stall counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  instruction fetch request; held until i_gnt.
- i_addr  in  ADDR_W  fetch address.
- i_gnt  out  1  fetch request accepted this cycle.
- i_rvalid  out  1  fetch data valid.
- i_rdata  out  DATA_W  fetch data.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  DATA_W/8  store byte enables.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  load data valid, or store acknowledge.
- d_rdata  out  DATA_W  load data.
- m_req  out  1  memory request.
- m_we  out  1  memory write.
- m_be  out  DATA_W/8  memory byte enables.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_gnt  in  1  memory accepts request this cycle.
- m_rvalid  in  1  memory response, for reads and writes; at least 1 cycle after m_gnt.
- m_rdata  in  DATA_W  memory read data.
- i_stall_cnt  out  CNT_W  cycles with i_req=1 and i_gnt=0.
- d_stall_cnt  out  CNT_W  cycles with d_req=1 and d_gnt=0.

Behaviour:
- Reset:
  - state=IDLE, owner=I, last=I, both counters=0.
  - While rst=1, m_req, i_gnt, d_gnt, i_rvalid and d_rvalid are all 0.
- States:
  - IDLE: no transaction outstanding.
  - BUSY: one transaction outstanding; the owner register holds I or D.
- Issue slot: open when state=IDLE, or when state=BUSY and m_rvalid=1 (back-to-back issue in the response cycle).
- Selection within an open slot:
  - Fixed priority, D over I.
  - Selected port's fields drive m_*; for I, m_we=0, m_be=all ones, m_wdata=0.
  - m_req = open slot and any request pending.
- Grant:
  - x_gnt = m_req & m_gnt & (sel==x), combinational same cycle.
  - On grant: owner<=sel, state<=BUSY.
- Response:
  - In BUSY with m_rvalid=1: owner's x_rvalid=1 for exactly that cycle.
  - If no new grant occurs in that cycle, state<=IDLE.
  - i_rdata and d_rdata both always equal m_rdata; consumers qualify with rvalid.
- Unmatched response: m_rvalid in IDLE is ignored; no rvalid is raised.
- m_gnt=0 while m_req=1: no state change. Requesters hold their request; the arbiter may reselect next cycle if priority changes.
- Reset mid-transaction: outstanding state is discarded; a late m_rvalid after reset is ignored (IDLE rule).
- Counters: increment per stall cycle and saturate at all ones; no wrap.
- Throughput: maximum one grant per cycle; latency request to rvalid = memory latency; the arbiter adds 0 cycles.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - When i_req and d_req are both pending in an open slot, grant goes to the port not equal to `last`.
  - last<=sel on each grant.
  - Single requester is always served.
- Undefined: fixed D-over-I priority; the `last` register is not built.

Test Plan:
- Single fetch: i_req, i_addr=0x44, m_gnt=1, m_rvalid 1 cycle later with m_rdata=0x00000013 -> i_gnt in cycle 0; i_rvalid=1 and i_rdata=0x13 in cycle 1; d_rvalid=0.
- Conflict, fixed priority: i_req and d_req (load 0x2000) in the same cycle -> d_gnt first, i_stall_cnt=1; i_gnt in the m_rvalid cycle (back-to-back); no idle bubble.
- Store ack: d_we=1, d_be=4'b0011, d_addr=0x2004, d_wdata=0xdeadbeef -> m_be=0011, m_wdata=0xdeadbeef; d_rvalid on the ack.
- Memory backpressure: m_gnt=0 for 3 cycles with i_req held -> i_gnt=0 for 3 cycles, i_stall_cnt=3, then grant.
- Reset mid-transaction: grant D, assert rst before m_rvalid, deassert, then inject m_rvalid -> no d_rvalid, counters=0, state IDLE.
- MEM_ARB_RR_EN: both ports requesting continuously -> grants alternate D, I, D, I; disabled -> D only while d_req=1; saturation at CNT_W=4 holds 15.
